// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, mode constants and helpers for SDF FFT stages
package fft_pkg;

  localparam int MODE_BF2I  = 0;
  localparam int MODE_BF2II = 1;

  // Carrier width for complex values; stages slice their own width out of it
  localparam int CPLX_W = 32;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Multiply by -j: (re, im) -> (im, -re)
  function automatic cplx_t rotate_mj(input cplx_t x);
    cplx_t y;
    y.re = x.im;
    y.im = -x.re;
    return y;
  endfunction

endpackage

// File: rtl/sdf_r22_stage_if.sv
// rtl/sdf_r22_stage_if.sv - sample stream into and out of one SDF stage
interface sdf_r22_stage_if #(
  parameter int DW = 16,
  parameter int OW = 16
);
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic                 out_valid;
  logic                 out_sof;
  logic signed [OW-1:0] out_r;
  logic signed [OW-1:0] out_i;
  logic                 frame_err;

  modport master (
    output in_valid, in_sof, in_r, in_i,
    input  out_valid, out_sof, out_r, out_i, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_i,
    output out_valid, out_sof, out_r, out_i, frame_err
  );
endinterface

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - DEPTH-sample feedback delay advancing only on en
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 1) begin : g_reg
    logic [W-1:0] dly_q;

    // single-sample delay is just one register
    always_ff @(posedge CLK) begin
      if (RST) dly_q <= '0;
      else if (en) dly_q <= din;
    end

    assign dout = dly_q;
  end else begin : g_ram
    localparam int PW = clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q;

    // pointer marks the oldest entry; it is read and overwritten in the same cycle
    always_ff @(posedge CLK) begin
      if (RST) ptr_q <= '0;
      else if (en) ptr_q <= ptr_q + PW'(1);
    end

    // storage carries no reset; stale contents are masked upstream
    always_ff @(posedge CLK) begin
      if (en) mem_q[ptr_q] <= din;
    end

    assign dout = mem_q[ptr_q];
  end

endmodule

// File: rtl/sdf_r22_stage.sv
// rtl/sdf_r22_stage.sv - radix-2^2 SDF FFT stage: butterfly, feedback delay, optional -j rotation
module sdf_r22_stage
  import fft_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 128,
  parameter int MODE  = MODE_BF2I,
  parameter int SCALE = 1
) (
  input logic            CLK,
  input logic            RST,
  sdf_r22_stage_if.slave bus
);

  localparam int W  = DW + 1;
  localparam int OW = DW + 1 - SCALE;
  localparam int HB = clog2(DEPTH);
  localparam int CW = (MODE == MODE_BF2II) ? HB + 2 : HB + 1;

  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_eff;
  logic                primed_q, primed_d;
  logic                resync, half_sel, rot;
  logic [2*W-1:0]      dly_dout;
  logic signed [W-1:0] xr, xi, ar, ai, br, bi;
  logic signed [W-1:0] res_r, res_i, wr_r, wr_i;
  logic signed [OW-1:0] out_r_d, out_i_d;
  cplx_t               xc, xrc;
  logic                unused_hi;
  logic                out_valid_q, out_sof_q, frame_err_q;
  logic signed [OW-1:0] out_r_q, out_i_q;

  // a start-of-frame on a non-zero count restarts the frame at index 0
  assign resync   = bus.in_valid && bus.in_sof && (cnt_q != '0);
  assign cnt_eff  = resync ? '0 : cnt_q;
  assign half_sel = cnt_eff[HB];
  assign primed_d = (primed_q && !resync) || half_sel;

  if (MODE == MODE_BF2II) begin : g_rot
    assign rot = (cnt_eff[CW-1 -: 2] == 2'b11);
  end else begin : g_norot
    assign rot = 1'b0;
  end

  assign xr = W'(bus.in_r);
  assign xi = W'(bus.in_i);

  sdf_delay_line #(.W(2 * W), .DEPTH(DEPTH)) u_dly (
    .CLK  (CLK),
    .RST  (RST),
    .en   (bus.in_valid),
    .din  ({wr_r, wr_i}),
    .dout (dly_dout)
  );

  assign ar = dly_dout[2*W-1:W];
  assign ai = dly_dout[W-1:0];

  // rotation widened so -(-2^(DW-1)) is representable
  assign unused_hi = ^{xrc.re[CPLX_W-1:W], xrc.im[CPLX_W-1:W]};

  // butterfly: fill half stores x and emits the stored difference; second half emits a+x, stores a-x
  always_comb begin
    xc.re = CPLX_W'(xr);
    xc.im = CPLX_W'(xi);
    xrc   = rot ? rotate_mj(xc) : xc;
    br    = W'(xrc.re);
    bi    = W'(xrc.im);
    if (half_sel) begin
      res_r = ar + br;
      res_i = ai + bi;
      wr_r  = ar - br;
      wr_i  = ai - bi;
    end else begin
      res_r = ar;
      res_i = ai;
      wr_r  = xr;
      wr_i  = xi;
    end
    out_r_d = OW'(res_r >>> SCALE);
    out_i_d = OW'(res_i >>> SCALE);
  end

  // counter, priming and registered outputs; everything holds while no sample arrives
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= resync;
      if (bus.in_valid) begin
        cnt_q       <= cnt_eff + CW'(1);
        primed_q    <= primed_d;
        out_valid_q <= primed_d;
        out_sof_q   <= (cnt_eff == CW'(DEPTH));
        out_r_q     <= out_r_d;
        out_i_q     <= out_i_d;
      end else begin
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_sdf_r22_stage.sv
// tb/tb_sdf_r22_stage.sv - scoreboard bench for sdf_r22_stage against a frame-level reference model
module tb_sdf_r22_stage;

  localparam int ND = 4;
  localparam int P_DW  [ND] = '{16, 16, 16, 8};
  localparam int P_DEP [ND] = '{2, 1, 1, 4};
  localparam int P_MODE[ND] = '{0, 1, 0, 1};
  localparam int P_SC  [ND] = '{0, 0, 1, 1};

  typedef struct {
    int idx;
    bit valid;
    bit sof;
    bit err;
    int r;
    int i;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid_v = 1'b0;
  logic in_sof_v = 1'b0;
  logic signed [15:0] in_r_v = '0;
  logic signed [15:0] in_i_v = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  rec_t sbq [ND][$];
  int   dl_r[ND][$];
  int   dl_i[ND][$];
  int   m_cnt[ND];
  bit   m_primed[ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdf_r22_stage_if #(.DW(16), .OW(17)) ifa ();
  sdf_r22_stage_if #(.DW(16), .OW(17)) ifb ();
  sdf_r22_stage_if #(.DW(16), .OW(16)) ifc ();
  sdf_r22_stage_if #(.DW(8),  .OW(8))  ifd ();

  assign ifa.in_valid = in_valid_v;  assign ifa.in_sof = in_sof_v;
  assign ifa.in_r = in_r_v;          assign ifa.in_i = in_i_v;
  assign ifb.in_valid = in_valid_v;  assign ifb.in_sof = in_sof_v;
  assign ifb.in_r = in_r_v;          assign ifb.in_i = in_i_v;
  assign ifc.in_valid = in_valid_v;  assign ifc.in_sof = in_sof_v;
  assign ifc.in_r = in_r_v;          assign ifc.in_i = in_i_v;
  assign ifd.in_valid = in_valid_v;  assign ifd.in_sof = in_sof_v;
  assign ifd.in_r = in_r_v[7:0];     assign ifd.in_i = in_i_v[7:0];

  sdf_r22_stage #(.DW(16), .DEPTH(2), .MODE(0), .SCALE(0)) u_a (.CLK(clk), .RST(rst), .bus(ifa));
  sdf_r22_stage #(.DW(16), .DEPTH(1), .MODE(1), .SCALE(0)) u_b (.CLK(clk), .RST(rst), .bus(ifb));
  sdf_r22_stage #(.DW(16), .DEPTH(1), .MODE(0), .SCALE(1)) u_c (.CLK(clk), .RST(rst), .bus(ifc));
  sdf_r22_stage #(.DW(8),  .DEPTH(4), .MODE(1), .SCALE(1)) u_d (.CLK(clk), .RST(rst), .bus(ifd));

  task automatic chk(input int d, input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", d, nm, act, exp, cyc);
    end
  endtask

  // Reference: a frame of L = 2*DEPTH (or 4*DEPTH) samples; the second half of each
  // 2*DEPTH block pairs with the sample DEPTH earlier, held in a plain FIFO.
  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_cnt[d] = 0;
      m_primed[d] = 0;
      dl_r[d].delete();
      dl_i[d].delete();
      for (int k = 0; k < P_DEP[d]; k++) begin
        dl_r[d].push_back(0);
        dl_i[d].push_back(0);
      end
    end
  endtask

  task automatic model_step(input int d, input bit sof, input int r_in, input int i_in);
    int sh, xr, xi, ar, ai, o_r, o_i, t, dep, blk;
    rec_t rc;
    sh  = 32 - P_DW[d];
    xr  = (r_in << sh) >>> sh;
    xi  = (i_in << sh) >>> sh;
    dep = P_DEP[d];
    rc.err = sof && (m_cnt[d] != 0);
    if (rc.err) begin
      m_cnt[d] = 0;
      m_primed[d] = 0;
    end
    blk = m_cnt[d] / dep;
    if (P_MODE[d] == 1 && blk == 3) begin
      t  = xr;
      xr = xi;
      xi = -t;
    end
    ar = dl_r[d].pop_front();
    ai = dl_i[d].pop_front();
    if (blk % 2 == 0) begin
      o_r = ar;
      o_i = ai;
      dl_r[d].push_back(xr);
      dl_i[d].push_back(xi);
    end else begin
      o_r = ar + xr;
      o_i = ai + xi;
      dl_r[d].push_back(ar - xr);
      dl_i[d].push_back(ai - xi);
      m_primed[d] = 1;
    end
    rc.idx   = cyc + 1;
    rc.valid = m_primed[d];
    rc.sof   = (m_cnt[d] == dep);
    rc.r     = o_r >>> P_SC[d];
    rc.i     = o_i >>> P_SC[d];
    if (rc.valid || rc.err) sbq[d].push_back(rc);
    m_cnt[d] = (m_cnt[d] + 1) % ((P_MODE[d] == 1 ? 4 : 2) * dep);
  endtask

  task automatic mon(input int d, input logic v, input logic s, input logic e, input int r, input int i);
    rec_t x;
    if (sbq[d].size() > 0 && sbq[d][0].idx == cyc) begin
      x = sbq[d].pop_front();
      chk(d, "out_valid", int'(v), int'(x.valid));
      chk(d, "frame_err", int'(e), int'(x.err));
      if (x.valid) begin
        chk(d, "out_sof", int'(s), int'(x.sof));
        chk(d, "out_r", r, x.r);
        chk(d, "out_i", i, x.i);
      end
    end else begin
      chk(d, "idle_valid_err", int'(v || e), 0);
    end
  endtask

  always @(negedge clk) mon(0, ifa.out_valid, ifa.out_sof, ifa.frame_err, int'(ifa.out_r), int'(ifa.out_i));
  always @(negedge clk) mon(1, ifb.out_valid, ifb.out_sof, ifb.frame_err, int'(ifb.out_r), int'(ifb.out_i));
  always @(negedge clk) mon(2, ifc.out_valid, ifc.out_sof, ifc.frame_err, int'(ifc.out_r), int'(ifc.out_i));
  always @(negedge clk) mon(3, ifd.out_valid, ifd.out_sof, ifd.frame_err, int'(ifd.out_r), int'(ifd.out_i));

  task automatic drive(input bit v, input bit s, input int r, input int i);
    @(negedge clk);
    #1;
    in_valid_v = v;
    in_sof_v   = s;
    in_r_v     = 16'(r);
    in_i_v     = 16'(i);
    if (v) begin
      for (int d = 0; d < ND; d++) model_step(d, s, r, i);
    end
  endtask

  task automatic rchk(input int d, input logic v, input logic s, input logic e, input int r, input int i);
    chk(d, "rst_out_valid", int'(v), 0);
    chk(d, "rst_out_sof", int'(s), 0);
    chk(d, "rst_frame_err", int'(e), 0);
    chk(d, "rst_out_r", r, 0);
    chk(d, "rst_out_i", i, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid_v = 1'b0;
    in_sof_v = 1'b0;
    @(negedge clk);
    rchk(0, ifa.out_valid, ifa.out_sof, ifa.frame_err, int'(ifa.out_r), int'(ifa.out_i));
    rchk(1, ifb.out_valid, ifb.out_sof, ifb.frame_err, int'(ifb.out_r), int'(ifb.out_i));
    rchk(2, ifc.out_valid, ifc.out_sof, ifc.frame_err, int'(ifc.out_r), int'(ifc.out_i));
    rchk(3, ifd.out_valid, ifd.out_sof, ifd.frame_err, int'(ifd.out_r), int'(ifd.out_i));
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int rnd16();
    logic [15:0] u;
    u = 16'($urandom);
    if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
    return int'($signed(u));
  endfunction

  task automatic frame_1234(input int gap);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 0, (k < 4) ? k + 1 : 0, 0);
      for (int g = 0; g < gap; g++) drive(1'b0, $urandom_range(0, 1) == 1, 99, -99);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    frame_1234(0);
    frame_1234(3);

    drive(1'b1, 1'b1, 5, 1);
    drive(1'b1, 1'b1, 7, -3);
    drive(1'b1, 1'b0, 8, 2);
    drive(1'b1, 1'b0, 9, 0);
    drive(1'b1, 1'b0, 10, -5);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 0, 0);

    drive(1'b1, 1'b1, 11, 12);
    drive(1'b1, 1'b0, 13, 14);
    do_reset();
    frame_1234(0);

    do_reset();
    drive(1'b1, 1'b1, 1, 0);
    drive(1'b1, 1'b0, 0, 1);
    drive(1'b1, 1'b0, 1, 0);
    drive(1'b1, 1'b0, 0, 1);
    drive(1'b1, 1'b0, 0, 0);

    do_reset();
    drive(1'b1, 1'b1, 32767, -32768);
    drive(1'b1, 1'b0, 32767, -32768);
    drive(1'b1, 1'b0, -32768, 32767);
    drive(1'b1, 1'b0, 32767, -32768);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd16(), rnd16());
    end

    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    for (int d = 0; d < ND; d++) chk(d, "scoreboard_drained", sbq[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
